// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 serial transmitter with a ready/valid byte input.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_transmitter #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic       serial_out
);

    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int CW = $clog2(SYMBOL_EDGE_TIME);
    localparam logic [CW-1:0] LAST = CW'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CW-1:0] PRE  = CW'(SYMBOL_EDGE_TIME - 2);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    logic par;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state;
    logic [7:0]    shreg;
    logic [2:0]    bit_idx;
    logic [CW-1:0] cyc;
    logic          accept;

    assign accept = data_in_valid && data_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            shreg         <= 8'h00;
            bit_idx       <= 3'd0;
            cyc           <= '0;
            serial_out    <= 1'b1;
            data_in_ready <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par           <= 1'b0;
`endif
        end else if (accept) begin
            // Accept can only happen in IDLE or the last STOP cycle
            state         <= START;
            shreg         <= data_in;
            bit_idx       <= 3'd0;
            cyc           <= '0;
            serial_out    <= 1'b0;
            data_in_ready <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par           <= ^data_in;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    serial_out    <= 1'b1;
                    data_in_ready <= 1'b1;
                    cyc           <= '0;
                end
                START: begin
                    if (cyc == LAST) begin
                        cyc        <= '0;
                        state      <= DATA;
                        serial_out <= shreg[0];
                        shreg      <= {1'b0, shreg[7:1]};
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                DATA: begin
                    if (cyc == LAST) begin
                        cyc <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state      <= PARITY;
                            serial_out <= par;
`else
                            state      <= STOP;
                            serial_out <= 1'b1;
`endif
                        end else begin
                            bit_idx    <= bit_idx + 1'b1;
                            serial_out <= shreg[0];
                            shreg      <= {1'b0, shreg[7:1]};
                        end
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (cyc == LAST) begin
                        cyc        <= '0;
                        state      <= STOP;
                        serial_out <= 1'b1;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (cyc == LAST) begin
                        cyc           <= '0;
                        state         <= IDLE;
                        serial_out    <= 1'b1;
                        data_in_ready <= 1'b1;
                    end else begin
                        cyc <= cyc + 1'b1;
                        // Ready rises early so a new byte lands on the last stop cycle
                        if (cyc == PRE) data_in_ready <= 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    serial_out    <= 1'b1;
                    data_in_ready <= 1'b1;
                    cyc           <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: directed frame checks for uart_transmitter.
// Build with UART_TX_PARITY_EN defined to exercise the parity frame.
module tb_uart_transmitter;

    localparam int SET = 434;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    typedef struct {
        logic [7:0]  data;
        logic [10:0] line;
        string       name;
        bit          busy;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_in_valid = 1'b0;
    logic       data_in_ready;
    logic       serial_out;

    int errors = 0;
    int checks = 0;
    vec_t tbl[$];

    uart_transmitter dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready),
        .serial_out   (serial_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic send(input logic [7:0] d);
        for (int k = 0; k < 20000 && data_in_ready !== 1'b1; k++) step();
        chk("ready_wait", data_in_ready, 1'b1);
        data_in = d;
        data_in_valid = 1'b1;
        step();
    endtask

    // Called just after the accept edge (cycle 1); returns at the last stop cycle
    task automatic check_frame(input vec_t v, input bit keep);
        for (int t = 1; t <= NB * SET; t++) begin
            if (t > 1) step();
            if (t == 1) begin
                chk({v.name, "_rdy_fall"}, data_in_ready, 1'b0);
                chk({v.name, "_start_edge"}, serial_out, 1'b0);
            end
            if (t % SET == SET / 2)
                chk($sformatf("%s_bit%0d", v.name, t / SET), serial_out, v.line[t / SET]);
            if (t == NB * SET - 1) begin
                chk({v.name, "_rdy_late"}, data_in_ready, 1'b0);
                if (!keep) data_in_valid = 1'b0;
            end
            if (t == NB * SET)
                chk({v.name, "_rdy_back"}, data_in_ready, 1'b1);
        end
    endtask

    task automatic check_idle(input string nm, input int n);
        logic ok;
        ok = 1'b1;
        for (int k = 0; k < n; k++) begin
            step();
            if (serial_out !== 1'b1 || data_in_ready !== 1'b1) ok = 1'b0;
        end
        chk(nm, ok, 1'b1);
    endtask

    initial begin
`ifdef UART_TX_PARITY_EN
        tbl.push_back('{8'hA5, 11'b10101001010, "A5", 1'b0});
        tbl.push_back('{8'h55, 11'b10010101010, "55", 1'b1});
        tbl.push_back('{8'h07, 11'b11000001110, "07", 1'b0});
`else
        tbl.push_back('{8'hA5, 11'b01101001010, "A5", 1'b0});
        tbl.push_back('{8'h55, 11'b01010101010, "55", 1'b1});
`endif

        for (int k = 0; k < 4; k++) begin
            step();
            chk("rst_serial", serial_out, 1'b1);
            chk("rst_ready", data_in_ready, 1'b1);
        end
        rst = 1'b0;
        step();
        chk("post_rst_serial", serial_out, 1'b1);
        chk("post_rst_ready", data_in_ready, 1'b1);

        for (int i = 0; i < tbl.size(); i++) begin
            send(tbl[i].data);
            if (tbl[i].busy) data_in = 8'h3C;
            else data_in_valid = 1'b0;
            check_frame(tbl[i], 1'b0);
            check_idle({tbl[i].name, "_idle"}, 300);
        end

        begin
            vec_t a, b;
`ifdef UART_TX_PARITY_EN
            a = '{8'h00, 11'b10000000000, "B2B00", 1'b0};
            b = '{8'hFF, 11'b10111111110, "B2BFF", 1'b0};
`else
            a = '{8'h00, 11'b01000000000, "B2B00", 1'b0};
            b = '{8'hFF, 11'b01111111110, "B2BFF", 1'b0};
`endif
            send(a.data);
            data_in = b.data;
            check_frame(a, 1'b1);
            step();
            check_frame(b, 1'b0);
            check_idle("b2b_idle", 300);
        end

        begin
            vec_t c;
`ifdef UART_TX_PARITY_EN
            c = '{8'h7E, 11'b10011111100, "7E", 1'b0};
`else
            c = '{8'h7E, 11'b01011111100, "7E", 1'b0};
`endif
            send(8'h81);
            data_in_valid = 1'b0;
            for (int t = 2; t <= 2000; t++) step();
            chk("mid_81_d3", serial_out, 1'b0);
            rst = 1'b1;
            data_in = 8'hC3;
            data_in_valid = 1'b1;
            step();
            chk("mid_rst_serial_2001", serial_out, 1'b1);
            chk("mid_rst_ready_2001", data_in_ready, 1'b1);
            step();
            chk("mid_rst_serial_2002", serial_out, 1'b1);
            chk("mid_rst_ready_2002", data_in_ready, 1'b1);
            rst = 1'b0;
            data_in_valid = 1'b0;
            check_idle("rst_no_accept", 50);
            send(c.data);
            data_in_valid = 1'b0;
            check_frame(c, 1'b0);
            check_idle("7E_idle", 300);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
